// File: rtl/cpr_pkg.sv
// Shared constants and types for the compressor framing stage.
package cpr_pkg;

  localparam logic [31:0] MAGIC      = 32'hC0DE_F00D;

  // Trailer field offsets within the output beat
  localparam int          MAGIC_LSB  = 0;
  localparam int          BYTES_LSB  = 32;
  localparam int          BEATS_LSB  = 64;
  localparam int          INDEX_LSB  = 96;

  localparam int          FIFO_DEPTH = 4;
  localparam int          CNT_W      = 3;   // holds 0..FIFO_DEPTH

  typedef enum logic {PASS, TRAILER} state_e;

endpackage

// File: rtl/cpr_skid_fifo.sv
// Four-entry skid FIFO absorbing beats that arrive after the credit drops.
// A push into a full FIFO is dropped (even with a same-cycle pop) and flagged.
module cpr_skid_fifo #(
  parameter int WIDTH = 289
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      empty,
  output logic [cpr_pkg::CNT_W-1:0] count,
  output logic                      overflow
);
  import cpr_pkg::*;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [1:0]       wr_ptr, rd_ptr;
  logic             full, push_ok, pop_ok;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 2'd1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if (push && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/cpr_frame_trailer.sv
// Passes compressed beats through (last flag cleared) and appends a trailer
// beat per frame carrying byte count, beat count and frame index.
module cpr_frame_trailer #(
  parameter int          DATA_WIDTH = 256,
  parameter int          KEEP_WIDTH = 32,
  parameter int          CNT_WIDTH  = 32,
  parameter logic [31:0] MAGIC      = cpr_pkg::MAGIC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [KEEP_WIDTH-1:0] s_keep,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [KEEP_WIDTH-1:0] m_keep,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  err_overflow
);
  import cpr_pkg::*;

  localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1;

  state_e                    state;
  logic [CNT_WIDTH-1:0]      byte_cnt, beat_cnt, frame_idx;
  logic [EW-1:0]             head;
  logic [DATA_WIDTH-1:0]     head_data;
  logic [KEEP_WIDTH-1:0]     head_keep;
  logic                      head_last;
  logic                      empty, pop;
  logic [CNT_W-1:0]          count;
  logic [5:0]                keep_ones;

  cpr_skid_fifo #(.WIDTH(EW)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (s_valid),
    .wdata    ({s_last, s_keep, s_data}),
    .pop      (pop),
    .rdata    (head),
    .empty    (empty),
    .count    (count),
    .overflow (err_overflow)
  );

  assign {head_last, head_keep, head_data} = head;
  assign s_ready = (count <= CNT_W'(2));
  assign pop     = (state == PASS) && !empty && m_ready;

  // Byte count of the head beat
  always_comb begin
    keep_ones = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) keep_ones = keep_ones + 6'(head_keep[i]);
  end

  // Output mux: FIFO head in PASS, trailer word in TRAILER
  always_comb begin
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_keep  = '0;
    m_data  = '0;
    if (state == TRAILER) begin
      m_valid                          = 1'b1;
      m_last                           = 1'b1;
      m_keep                           = '1;
      m_data[MAGIC_LSB +: 32]          = MAGIC;
      m_data[BYTES_LSB +: CNT_WIDTH]   = byte_cnt;
      m_data[BEATS_LSB +: CNT_WIDTH]   = beat_cnt;
      m_data[INDEX_LSB +: CNT_WIDTH]   = frame_idx;
    end else if (!empty) begin
      m_valid = 1'b1;
      m_data  = head_data;
      m_keep  = head_keep;
    end
  end

  // Frame state machine and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= PASS;
      byte_cnt  <= '0;
      beat_cnt  <= '0;
      frame_idx <= '0;
    end else begin
      case (state)
        PASS: if (pop) begin
          beat_cnt <= beat_cnt + CNT_WIDTH'(1);
          byte_cnt <= byte_cnt + CNT_WIDTH'(keep_ones);
          if (head_last) state <= TRAILER;
        end
        TRAILER: if (m_ready) begin
          frame_idx <= frame_idx + CNT_WIDTH'(1);
          byte_cnt  <= '0;
          beat_cnt  <= '0;
          state     <= PASS;
        end
        default: state <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_cpr_frame_trailer.sv
// Bench for cpr_frame_trailer: directed frames plus random traffic checked
// against a transaction-level model (beat queue + frame counters).
module tb_cpr_frame_trailer;

  localparam logic [31:0] MAGIC_C = 32'hC0DE_F00D;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [255:0] s_data = '0;
  logic [31:0]  s_keep = '0;
  logic         s_last = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [255:0] m_data;
  logic [31:0]  m_keep;
  logic         m_last;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         err_overflow;

  int checks = 0;
  int failures = 0;

  // reference model state
  beat_t        q[$];
  bit           in_tr = 1'b0;
  bit           ovf = 1'b0;
  bit           prev_rdy = 1'b1;
  logic [31:0]  mb_bytes = '0, mb_beats = '0, mb_frame = '0;
  logic [255:0] last_tr = '0;

  cpr_frame_trailer dut (
    .clk          (clk),
    .reset        (reset),
    .s_data       (s_data),
    .s_keep       (s_keep),
    .s_last       (s_last),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_keep       (m_keep),
    .m_last       (m_last),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_trailer();
    return {128'b0, mb_frame, mb_beats, mb_bytes, MAGIC_C};
  endfunction

  function automatic logic [255:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] rnd_keep();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic step(input bit sv, input logic [255:0] d, input logic [31:0] k,
                      input bit l, input bit mr);
    bit    ev, full;
    beat_t h;
    @(negedge clk);
    s_valid = sv; s_data = d; s_keep = k; s_last = l; m_ready = mr;
    #1;
    ev = in_tr || (q.size() != 0);
    chk("m_valid", m_valid, ev);
    if (in_tr) begin
      chk("trl_data", m_data, exp_trailer());
      chk("trl_keep", m_keep, 32'hFFFF_FFFF);
      chk("trl_last", m_last, 1'b1);
    end else if (ev) begin
      h = q[0];
      chk("beat_data", m_data, h.d);
      chk("beat_keep", m_keep, h.k);
      chk("beat_last", m_last, 1'b0);
    end
    chk("s_ready", s_ready, q.size() <= 2);
    chk("err_overflow", err_overflow, ovf);
    prev_rdy = s_ready;
    full = (q.size() == 4);
    if (ev && mr) begin
      if (in_tr) begin
        last_tr  = m_data;
        mb_frame = mb_frame + 1;
        mb_bytes = '0;
        mb_beats = '0;
        in_tr    = 1'b0;
      end else begin
        h        = q.pop_front();
        mb_beats = mb_beats + 1;
        mb_bytes = mb_bytes + 32'($countones(h.k));
        if (h.l) in_tr = 1'b1;
      end
    end
    if (sv) begin
      if (full) ovf = 1'b1;
      else q.push_back({d, k, l});
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((q.size() != 0 || in_tr) && g < 100) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      g++;
    end
    chk("drain_done", (q.size() == 0) && !in_tr, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; m_ready = 1'b0;
    q.delete();
    in_tr = 1'b0; ovf = 1'b0; prev_rdy = 1'b1;
    mb_bytes = '0; mb_beats = '0; mb_frame = '0;
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_m_keep", m_keep, '0);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_err", err_overflow, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send_rand_frame(input int n, input bit rnd_ready);
    int sent = 0;
    int guard = 0;
    bit mr;
    while (sent < n && guard < 200) begin
      mr = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (prev_rdy && $urandom_range(0, 4) != 0) begin
        step(1'b1, rnd_data(), rnd_keep(), sent == n - 1, mr);
        sent++;
      end else begin
        step(1'b0, '0, '0, 1'b0, mr);
      end
      guard++;
    end
    chk("send_done", sent, n);
  endtask

  initial begin
    int sent;
    do_reset();

    // single one-beat frame
    step(1'b1, rnd_data(), 32'hFFFF_FFFF, 1'b1, 1'b1);
    drain();
    chk("t1_bytes", last_tr[63:32], 32);
    chk("t1_beats", last_tr[95:64], 1);
    chk("t1_index", last_tr[127:96], 0);
    chk("t1_magic", last_tr[31:0], 32'hC0DE_F00D);

    // three-beat frame, then a one-beat frame
    step(1'b1, rnd_data(), 32'hFFFF_FFFF, 1'b0, 1'b1);
    step(1'b1, rnd_data(), 32'hFFFF_FFFF, 1'b0, 1'b1);
    step(1'b1, rnd_data(), 32'h0000_000F, 1'b1, 1'b1);
    drain();
    chk("t2_bytes", last_tr[63:32], 68);
    chk("t2_beats", last_tr[95:64], 3);
    chk("t2_index", last_tr[127:96], 1);
    step(1'b1, rnd_data(), 32'h0000_00FF, 1'b1, 1'b1);
    drain();
    chk("t2b_index", last_tr[127:96], 2);
    chk("t2b_bytes", last_tr[63:32], 8);

    // backpressure with a source honouring s_ready one cycle late
    sent = 0;
    for (int c = 0; c < 60 && sent < 6; c++) begin
      if (prev_rdy) begin
        step(1'b1, rnd_data(), 32'hFFFF_FFFF, sent == 5, c >= 10);
        sent++;
      end else begin
        step(1'b0, '0, '0, 1'b0, c >= 10);
      end
    end
    chk("bp_sent", sent, 6);
    drain();
    chk("bp_bytes", last_tr[63:32], 192);
    chk("bp_beats", last_tr[95:64], 6);
    chk("bp_no_ovf", err_overflow, 1'b0);

    // overflow: five pushes into a stalled output
    for (int i = 0; i < 5; i++) step(1'b1, rnd_data(), rnd_keep(), i >= 3, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("ovf_set", err_overflow, 1'b1);
    drain();
    chk("ovf_beats", last_tr[95:64], 4);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("ovf_sticky", err_overflow, 1'b1);

    // zero-keep beat inside a two-beat frame
    step(1'b1, rnd_data(), 32'h0, 1'b0, 1'b1);
    step(1'b1, rnd_data(), 32'hFFFF_FFFF, 1'b1, 1'b1);
    drain();
    chk("k0_bytes", last_tr[63:32], 32);
    chk("k0_beats", last_tr[95:64], 2);

    // reset in the middle of a four-beat frame
    step(1'b1, rnd_data(), rnd_keep(), 1'b0, 1'b1);
    step(1'b1, rnd_data(), rnd_keep(), 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    do_reset();
    step(1'b1, rnd_data(), 32'h0000_FFFF, 1'b1, 1'b1);
    drain();
    chk("rst_index", last_tr[127:96], 0);
    chk("rst_beats", last_tr[95:64], 1);
    chk("rst_bytes", last_tr[63:32], 16);

    // random traffic with random downstream stalls
    for (int f = 0; f < 20; f++) send_rand_frame($urandom_range(1, 5), 1'b1);
    drain();
    chk("rand_frames", mb_frame, 21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
